// File: rtl/fixed_divider.sv
// fixed_divider: sequential unsigned fixed-point divider (INT_BITS.FRAC_BITS).
// Restoring shift/subtract that retires one quotient bit per clock, behind a
// start/busy/done handshake. Dividend is num1 scaled up by FRAC_BITS so the
// quotient comes back in the same fixed-point format as the operands.
// Optional feature macro: FIXED_DIV_ROUND_EN. When it is defined, one extra
// guard iteration is run and the quotient is rounded half up. Otherwise the
// quotient is truncated toward zero.
module fixed_divider #(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8,
  localparam int W = INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         precision_lost,
  output logic         div_zero
);

  // Full quotient width: the dividend is {num1, FRAC_BITS zeros}.
  localparam int N = W + FRAC_BITS;
`ifdef FIXED_DIV_ROUND_EN
  // One extra iteration produces the guard bit just below the result LSB.
  localparam int ITERS = N + 1;
`else
  localparam int ITERS = N;
`endif
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [ITERS-1:0]   r_dvd;      // dividend bits still to be shifted in, MSB first
  logic [W-1:0]       r_div;      // latched divisor
  logic [W:0]         r_rem;      // partial remainder, one spare bit for the borrow
  logic [ITERS-2:0]   r_quo;      // quotient bits retired so far
  logic [4:0]         r_cnt;      // iteration counter

  logic [W-1:0]       r_result;
  logic               r_overflow;
  logic               r_precision_lost;
  logic               r_div_zero;

  logic               w_divisor_zero;
  logic               w_last;
  logic [W:0]         w_trial;
  logic               w_qbit;
  logic [W:0]         w_rem_next;
  logic [ITERS-1:0]   w_quo_next;
  logic [W-1:0]       w_result;
  logic               w_overflow;
  logic               w_precision_lost;
`ifdef FIXED_DIV_ROUND_EN
  logic [N:0]         w_q_round;
`endif

  assign w_divisor_zero = (num2 == '0);
  assign w_last         = (r_cnt == LAST_ITER);

  assign result         = r_result;
  assign overflow       = r_overflow;
  assign precision_lost = r_precision_lost;
  assign div_zero       = r_div_zero;

  // State register; reset drops any division in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_divisor_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start in the done cycle is taken immediately (back-to-back).
        if (start) begin
          w_state_next = w_divisor_zero ? S_DONE : S_CALC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_trial    = (r_rem << 1) | {{W{1'b0}}, r_dvd[ITERS-1]};
    w_qbit     = (w_trial >= {1'b0, r_div});
    w_rem_next = w_qbit ? (w_trial - {1'b0, r_div}) : w_trial;
    w_quo_next = {r_quo, w_qbit};
  end

  // Final result and flags, formed from the last iteration's quotient.
  always_comb begin
`ifdef FIXED_DIV_ROUND_EN
    // Drop the guard bit and add it back in: round half up. The remainder
    // after N bits is nonzero exactly when the guard bit or the final
    // remainder is nonzero.
    w_q_round        = {1'b0, w_quo_next[ITERS-1:1]} + {{N{1'b0}}, w_quo_next[0]};
    w_result         = w_q_round[W-1:0];
    w_overflow       = |w_q_round[N:W];
    w_precision_lost = w_quo_next[0] | (|w_rem_next);
`else
    w_result         = w_quo_next[W-1:0];
    w_overflow       = |w_quo_next[N-1:W];
    w_precision_lost = |w_rem_next;
`endif
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd            <= '0;
      r_div            <= '0;
      r_rem            <= '0;
      r_quo            <= '0;
      r_cnt            <= '0;
      r_result         <= '0;
      r_overflow       <= 1'b0;
      r_precision_lost <= 1'b0;
      r_div_zero       <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next[ITERS-2:0];
      r_dvd <= {r_dvd[ITERS-2:0], 1'b0};
      r_cnt <= r_cnt + 5'd1;
      if (w_last) begin
        r_result         <= w_result;
        r_overflow       <= w_overflow;
        r_precision_lost <= w_precision_lost;
      end
    end else if (start) begin
      // Accepted start (IDLE or DONE): flags clear, result holds until DONE.
      r_overflow       <= 1'b0;
      r_precision_lost <= 1'b0;
      if (w_divisor_zero) begin
        r_result   <= '1;
        r_div_zero <= 1'b1;
      end else begin
        r_div_zero <= 1'b0;
        r_dvd      <= {num1, {(ITERS-W){1'b0}}};
        r_div      <= num2;
        r_rem      <= '0;
        r_quo      <= '0;
        r_cnt      <= '0;
      end
    end
  end

endmodule
